// File: rtl/ff_if.sv
// Serial pattern detector interface.
//   x          serial data bit, driven by the bit source (master)
//   y          one-cycle match flag, driven by the detector (slave)
//   match_cnt  saturating match count, present only with FF_MATCH_CNT_EN
// Macro: FF_MATCH_CNT_EN adds match_cnt to the bundle and to both modports.
interface ff_if #(
    parameter int CNT_W = 8
);
    logic x;
    logic y;
`ifdef FF_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;

    modport master (output x, input y, input match_cnt);
    modport slave  (input x, output y, output match_cnt);
`else
    modport master (output x, input y);
    modport slave  (input x, output y);
`endif
endinterface

// File: rtl/ff.sv
// Moore FSM detecting the serial pattern 1-0-1-0-1 on bus.x, one bit per
// rising clk edge. bus.y is high for exactly one cycle in the state that
// follows a completed match and is decoded from the state register only.
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   nrst  asynchronous active-low reset
//   bus   ff_if.slave: x in, y out (match_cnt out with FF_MATCH_CNT_EN)
// Parameters:
//   OVERLAP  1: tail "1010" of a match seeds the next; 0: restart after match
//   CNT_W    width of the optional saturating match counter
// Macro: FF_MATCH_CNT_EN enables bus.match_cnt and its counter.
//
// state | meaning (prefix matched)
// S0    | nothing
// S1    | "1"
// S2    | "10"
// S3    | "101"
// S4    | "1010"
// S5    | "10101" - match, y high
module ff #(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic nrst,
    ff_if.slave  bus
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("ff: CNT_W must be at least 1");
    end

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S0;
        case (state)
            S0: state_nxt = bus.x ? S1 : S0;
            S1: state_nxt = bus.x ? S1 : S2;
            S2: state_nxt = bus.x ? S3 : S0;
            S3: state_nxt = bus.x ? S1 : S4;
            S4: state_nxt = bus.x ? S5 : S0;
            // After a match the trailing "1010" is only reusable with OVERLAP.
            S5: state_nxt = bus.x ? S1 : (OVERLAP ? S4 : S0);
            // Unused encodings recover to idle.
            default: state_nxt = S0;
        endcase
    end

    assign bus.y = (state == S5);

`ifdef FF_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Counts on the edge that enters S5, so it moves together with y.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if ((state_nxt == S5) && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt;
`endif

endmodule

// File: tb/tb_ff.sv
`timescale 1ns/100ps
module tb_ff;
    localparam int CW = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic xd   = 1'b0;

    always #5 clk = ~clk;

    ff_if #(.CNT_W(CW)) bus1 ();
    ff_if #(.CNT_W(CW)) bus0 ();
    assign bus1.x = xd;
    assign bus0.x = xd;

    ff #(.OVERLAP(1'b1), .CNT_W(CW)) dut1 (.clk(clk), .nrst(nrst), .bus(bus1));
    ff #(.OVERLAP(1'b0), .CNT_W(CW)) dut0 (.clk(clk), .nrst(nrst), .bus(bus0));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: last five bits plus the length of the window that
    // may contribute to a match (since reset; for non-overlap also since
    // the previous match).
    logic [4:0] sh = '0;
    int win1 = 0, win0 = 0;
    int cnt1 = 0, cnt0 = 0;
    bit e1 = 1'b0, e0 = 1'b0;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        bit rst;
        bit x;
        bit y1;
        bit y0;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        sh = '0; win1 = 0; win0 = 0; cnt1 = 0; cnt0 = 0; e1 = 1'b0; e0 = 1'b0;
    endtask

    task automatic model_step(input bit b);
        sh = {sh[3:0], b};
        win1++;
        win0++;
        e1 = (win1 >= 5) && (sh == 5'b10101);
        e0 = (win0 >= 5) && (sh == 5'b10101);
        if (e0) win0 = 0;
        if (e1 && cnt1 < CMAX) cnt1++;
        if (e0 && cnt0 < CMAX) cnt0++;
    endtask

    task automatic check_model(input string tag);
        check({tag, " y ovl1"}, int'(bus1.y), int'(e1));
        check({tag, " y ovl0"}, int'(bus0.y), int'(e0));
`ifdef FF_MATCH_CNT_EN
        check({tag, " cnt ovl1"}, int'(bus1.match_cnt), cnt1);
        check({tag, " cnt ovl0"}, int'(bus0.match_cnt), cnt0);
`endif
    endtask

    // Entered at posedge+1; nrst low for 3 ns, entirely between edges.
    task automatic pulse_reset();
        nrst = 1'b0;
        model_reset();
        #1;
        check("async reset y ovl1", int'(bus1.y), 0);
        check("async reset y ovl0", int'(bus0.y), 0);
`ifdef FF_MATCH_CNT_EN
        check("async reset cnt", int'(bus1.match_cnt), 0);
`endif
        #2;
        nrst = 1'b1;
    endtask

    // x changes mid-cycle; outputs sampled 1 ns after the rising edge.
    task automatic apply_bit(input bit b);
        @(negedge clk);
        xd = b;
        @(posedge clk);
        #1;
        model_step(b);
    endtask

    task automatic add_seq(input bit r, input int n, input logic [31:0] bits,
                           input logic [31:0] m1, input logic [31:0] m0);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.rst = r && (k == 0);
            v.x   = bits[n-1-k];
            v.y1  = m1[n-1-k];
            v.y0  = m0[n-1-k];
            tbl.push_back(v);
        end
    endtask

    initial begin
        // Reset held from t=0 with x toggling; released at 6 ns.
        xd = 1'b1;
        #2;
        check("in reset y ovl1", int'(bus1.y), 0);
        check("in reset y ovl0", int'(bus0.y), 0);
        xd = 1'b0;
        #4;
        check("reset past edge y", int'(bus1.y), 0);
`ifdef FF_MATCH_CNT_EN
        check("reset cnt", int'(bus1.match_cnt), 0);
`endif
        nrst = 1'b1;

        // Single match
        add_seq(1'b0, 5, 32'b10101, 32'b00001, 32'b00001);
        // Overlap stream
        add_seq(1'b1, 26, 32'b10101_01101_01011_01010_01010_1,
                          32'b00001_01000_01010_00010_00000_1,
                          32'b00001_00000_01000_00010_00000_1);
        // Near-misses, then completion
        add_seq(1'b1, 13, 32'b10100_10110_101, 32'b00000_00000_001,
                          32'b00000_00000_001);
        // Mid-pattern reset: partial 1010 discarded, next 1 lands in S1
        add_seq(1'b1, 4, 32'b1010, 32'b0000, 32'b0000);
        add_seq(1'b1, 5, 32'b10101, 32'b00001, 32'b00001);
        // Back-to-back after a fresh start, then a trailing zero
        add_seq(1'b1, 8, 32'b1010_1010, 32'b0000_1010, 32'b0000_1000);

        foreach (tbl[i]) begin
            if (tbl[i].rst) pulse_reset();
            apply_bit(tbl[i].x);
            check($sformatf("vec%0d y ovl1", i), int'(bus1.y), int'(tbl[i].y1));
            check($sformatf("vec%0d y ovl0", i), int'(bus0.y), int'(tbl[i].y0));
            check_model($sformatf("vec%0d model", i));
        end

        // Randomized stream with occasional asynchronous resets.
        pulse_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            apply_bit(1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
